// File: rtl/ads5296_tx_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ads5296_tx_pkg
// Brief    : Shared constants, types and helpers for the ADS5296 2-wire
//            LVDS transmit serializer.
// Revision : 1.0 - initial release
// ============================================================================
package ads5296_tx_pkg;

  // Each ADC channel is carried on two serial lanes
  localparam int LANES_PER_CH    = 2;
  // Frame clock is high for the first three bit slots of a frame
  localparam int FCLK_HIGH_SLOTS = 3;

  // Bit-slot counter; wide enough for sample widths up to 16 bits
  typedef logic [2:0] bit_cnt_t;

  // Number of bits each lane carries per frame
  function automatic int bits_per_lane(input int bits);
    return bits / LANES_PER_CH;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ads5296_tx_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : ads5296_tx_serializer_if
// Brief    : Sample/handshake bus and serial-side outputs of the ADS5296
//            transmit serializer. master = sample source, slave = serializer.
// Revision : 1.0 - initial release
// ============================================================================
interface ads5296_tx_serializer_if
  import ads5296_tx_pkg::*;
#(
  parameter int G_NUM_CHANNELS = 4,
  parameter int G_BITS         = 10
);

  logic                                  sync;
  logic [G_BITS*G_NUM_CHANNELS-1:0]      din;
  logic                                  din_valid;
  logic                                  din_ready;
  logic [LANES_PER_CH*G_NUM_CHANNELS-1:0] dout;
  logic                                  fclk_out;
  logic                                  frame_start;
  logic                                  sync_out;
  logic [15:0]                           underflow_cnt;

  modport master (
    output sync, din, din_valid,
    input  din_ready, dout, fclk_out, frame_start, sync_out, underflow_cnt
  );

  modport slave (
    input  sync, din, din_valid,
    output din_ready, dout, fclk_out, frame_start, sync_out, underflow_cnt
  );

endinterface
`default_nettype wire

// File: rtl/ads5296_tx_serializer_lane_shifter.sv
`default_nettype none
// ============================================================================
// Module   : ads5296_lane_shifter
// Brief    : One channel's pair of lane shift registers. Upper half of the
//            sample goes to lane_hi, lower half to lane_lo, MSB first.
// Revision : 1.0 - initial release
// ============================================================================
module ads5296_lane_shifter
  import ads5296_tx_pkg::*;
#(
  parameter int              G_BITS      = 10,
  parameter logic [G_BITS-1:0] G_IDLE_WORD = '0
)(
  input  logic              lclk,
  input  logic              rst,
  input  logic              load,
  input  logic [G_BITS-1:0] load_word,
  output logic              lane_hi,
  output logic              lane_lo
);

  localparam int c_BPL = bits_per_lane(G_BITS);

  logic [c_BPL-1:0] r_sr_hi;
  logic [c_BPL-1:0] r_sr_lo;

  // Parallel load at frame boundary, otherwise shift one bit toward the MSB
  always_ff @(posedge lclk or posedge rst) begin
    if (rst) begin
      r_sr_hi <= G_IDLE_WORD[G_BITS-1 -: c_BPL];
      r_sr_lo <= G_IDLE_WORD[c_BPL-1:0];
    end else if (load) begin
      r_sr_hi <= load_word[G_BITS-1 -: c_BPL];
      r_sr_lo <= load_word[c_BPL-1:0];
    end else begin
      r_sr_hi <= {r_sr_hi[c_BPL-2:0], 1'b0};
      r_sr_lo <= {r_sr_lo[c_BPL-2:0], 1'b0};
    end
  end

  assign lane_hi = r_sr_hi[c_BPL-1];
  assign lane_lo = r_sr_lo[c_BPL-1];

endmodule
`default_nettype wire

// File: rtl/ads5296_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : ads5296_tx_serializer
// Brief    : Transmit-side model of the ADS5296 2-wire LVDS link. Holds one
//            sample vector, serializes it MSB first onto two lanes per
//            channel and generates frame clock, frame_start and sync markers.
//            Optional macro ADS5296_TX_RAMP_EN adds a test_mode input that
//            replaces the sample stream with a per-channel ramp.
// Revision : 1.0 - initial release
// ============================================================================
module ads5296_tx_serializer
  import ads5296_tx_pkg::*;
#(
  parameter int                G_NUM_CHANNELS = 4,
  parameter int                G_BITS         = 10,
  parameter logic [G_BITS-1:0] G_IDLE_WORD    = '0
)(
  input  logic lclk,
  input  logic rst,
`ifdef ADS5296_TX_RAMP_EN
  input  logic test_mode,
`endif
  ads5296_tx_serializer_if.slave bus
);

  localparam int c_BPL = bits_per_lane(G_BITS);
  localparam int c_W   = G_BITS * G_NUM_CHANNELS;
  localparam int c_LW  = LANES_PER_CH * G_NUM_CHANNELS;

  bit_cnt_t         r_bit_cnt;
  logic             r_sync_d;
  logic             r_hold_full;
  logic             r_primed;
  logic [c_W-1:0]   r_hold;
  logic             r_fclk;
  logic             r_frame_start;
  logic             r_sync_out;
  logic [15:0]      r_underflow_cnt;
  logic [c_LW-1:0]  w_dout;

  logic w_test_mode;
  logic w_sync_edge;
  logic w_load;
  logic w_din_ready;
  logic w_accept;
  logic w_idle_load;

`ifdef ADS5296_TX_RAMP_EN
  assign w_test_mode = test_mode;
`else
  assign w_test_mode = 1'b0;
`endif

  assign w_sync_edge = bus.sync & ~r_sync_d;
  // A coincident sync edge and last slot still form a single load
  assign w_load      = (r_bit_cnt == bit_cnt_t'(c_BPL - 1)) | w_sync_edge;
  // Hold can be refilled in the same cycle it is drained by a load
  assign w_din_ready = (~r_hold_full | w_load) & ~w_test_mode;
  assign w_accept    = bus.din_valid & w_din_ready;
  assign w_idle_load = w_load & ~r_hold_full & ~w_test_mode;

  // Bit-slot counter, frame clock and frame/sync markers
  always_ff @(posedge lclk or posedge rst) begin
    if (rst) begin
      r_bit_cnt     <= bit_cnt_t'(c_BPL - 1);
      r_sync_d      <= 1'b0;
      r_fclk        <= 1'b0;
      r_frame_start <= 1'b0;
      r_sync_out    <= 1'b0;
    end else begin
      r_sync_d <= bus.sync;
      if (w_load) begin
        r_bit_cnt     <= '0;
        r_fclk        <= 1'b1;
        r_frame_start <= 1'b1;
        r_sync_out    <= w_sync_edge;
      end else begin
        r_bit_cnt     <= r_bit_cnt + 1'b1;
        r_fclk        <= (int'(r_bit_cnt) + 1) < FCLK_HIGH_SLOTS;
        r_frame_start <= 1'b0;
        r_sync_out    <= 1'b0;
      end
    end
  end

  // One-entry holding register; ramp mode leaves its contents untouched
  always_ff @(posedge lclk or posedge rst) begin
    if (rst) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_primed    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_hold      <= bus.din;
        r_hold_full <= 1'b1;
      end else if (w_load & ~w_test_mode) begin
        r_hold_full <= 1'b0;
      end
      r_primed <= r_primed | w_accept;
    end
  end

  // Saturating count of idle frames once real data has been seen
  always_ff @(posedge lclk or posedge rst) begin
    if (rst) begin
      r_underflow_cnt <= '0;
    end else if (w_idle_load & r_primed & (r_underflow_cnt != 16'hFFFF)) begin
      r_underflow_cnt <= r_underflow_cnt + 16'd1;
    end
  end

`ifdef ADS5296_TX_RAMP_EN
  logic [G_BITS-1:0] r_ramp [G_NUM_CHANNELS];

  // Per-channel ramp, channel c starting at c, advanced on each ramp frame
  always_ff @(posedge lclk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < G_NUM_CHANNELS; c++) r_ramp[c] <= G_BITS'(c);
    end else if (w_load & test_mode) begin
      for (int c = 0; c < G_NUM_CHANNELS; c++) r_ramp[c] <= r_ramp[c] + 1'b1;
    end
  end
`endif

  for (genvar c = 0; c < G_NUM_CHANNELS; c++) begin : g_ch
    logic [G_BITS-1:0] w_word;

`ifdef ADS5296_TX_RAMP_EN
    // Word for the next frame: ramp, held sample or idle pattern
    always_comb begin
      w_word = r_hold_full ? r_hold[G_BITS*c +: G_BITS] : G_IDLE_WORD;
      if (test_mode) w_word = r_ramp[c];
    end
`else
    // Word for the next frame: held sample or idle pattern
    always_comb begin
      w_word = r_hold_full ? r_hold[G_BITS*c +: G_BITS] : G_IDLE_WORD;
    end
`endif

    ads5296_lane_shifter #(
      .G_BITS      (G_BITS),
      .G_IDLE_WORD (G_IDLE_WORD)
    ) u_shifter (
      .lclk      (lclk),
      .rst       (rst),
      .load      (w_load),
      .load_word (w_word),
      .lane_hi   (w_dout[LANES_PER_CH*c]),
      .lane_lo   (w_dout[LANES_PER_CH*c + 1])
    );
  end

  assign bus.din_ready     = w_din_ready;
  assign bus.dout          = w_dout;
  assign bus.fclk_out      = r_fclk;
  assign bus.frame_start   = r_frame_start;
  assign bus.sync_out      = r_sync_out;
  assign bus.underflow_cnt = r_underflow_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ads5296_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ads5296_tx_serializer
// Brief    : Directed self-checking bench for ads5296_tx_serializer.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ads5296_tx_serializer;

  logic lclk;
  logic rst;
`ifdef ADS5296_TX_RAMP_EN
  logic test_mode = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  logic [4:0] cap_hi [4];
  logic [4:0] cap_lo [4];
  logic [4:0] cap_fclk;
  logic [4:0] cap_fs;
  logic [4:0] cap_sync;

  ads5296_tx_serializer_if #(.G_NUM_CHANNELS(4), .G_BITS(10)) bus ();

  ads5296_tx_serializer #(
    .G_NUM_CHANNELS (4),
    .G_BITS         (10),
    .G_IDLE_WORD    (10'h000)
  ) dut (
    .lclk      (lclk),
    .rst       (rst),
`ifdef ADS5296_TX_RAMP_EN
    .test_mode (test_mode),
`endif
    .bus       (bus)
  );

  initial lclk = 1'b0;
  always #5 lclk = ~lclk;

  task automatic tick();
    @(posedge lclk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.sync      = 1'b0;
    bus.din_valid = 1'b0;
    bus.din       = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Records the current sample as slot 0 and the next four slots
  task automatic capture();
    for (int s = 0; s < 5; s++) begin
      if (s > 0) tick();
      for (int c = 0; c < 4; c++) begin
        cap_hi[c] = {cap_hi[c][3:0], bus.dout[2*c]};
        cap_lo[c] = {cap_lo[c][3:0], bus.dout[2*c+1]};
      end
      cap_fclk = {cap_fclk[3:0], bus.fclk_out};
      cap_fs   = {cap_fs[3:0],   bus.frame_start};
      cap_sync = {cap_sync[3:0], bus.sync_out};
    end
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.sync      = 1'b0;
    bus.din_valid = 1'b0;
    bus.din       = '0;
    tick();
    tick();
    checks += 6;
    if (bus.dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", bus.dout); end
    if (bus.fclk_out !== 1'b0) begin errors++; $display("FAIL reset_fclk: got %b want 0", bus.fclk_out); end
    if (bus.frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start: got %b want 0", bus.frame_start); end
    if (bus.sync_out !== 1'b0) begin errors++; $display("FAIL reset_sync_out: got %b want 0", bus.sync_out); end
    if (bus.underflow_cnt !== 16'h0000) begin errors++; $display("FAIL reset_underflow: got %h want 0000", bus.underflow_cnt); end
    if (bus.din_ready !== 1'b1) begin errors++; $display("FAIL reset_din_ready: got %b want 1", bus.din_ready); end
  endtask

  task automatic test_single();
    logic [9:0] exp_w [4];
    exp_w = '{10'h2A5, 10'h15A, 10'h3C0, 10'h00F};
    do_reset();
    bus.din       = {10'h00F, 10'h3C0, 10'h15A, 10'h2A5};
    bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
    checks += 2;
    if (bus.frame_start !== 1'b1) begin errors++; $display("FAIL single_first_load: got %b want 1", bus.frame_start); end
    if (bus.din_ready !== 1'b0) begin errors++; $display("FAIL single_ready_full: got %b want 0", bus.din_ready); end
    repeat (5) tick();
    capture();
    // 2A5 -> hi 10101 lo 00101 ; 15A -> 01010/11010 ; 3C0 -> 11110/00000 ; 00F -> 00000/01111
    for (int c = 0; c < 4; c++) begin
      checks++;
      if ({cap_hi[c], cap_lo[c]} !== exp_w[c]) begin
        errors++; $display("FAIL single_word_ch%0d: got %h want %h", c, {cap_hi[c], cap_lo[c]}, exp_w[c]);
      end
    end
    checks++;
    if (cap_hi[0] !== 5'b10101 || cap_lo[0] !== 5'b00101) begin
      errors++; $display("FAIL single_lanes_ch0: got %b/%b want 10101/00101", cap_hi[0], cap_lo[0]);
    end
    checks += 3;
    if (cap_fclk !== 5'b11100) begin errors++; $display("FAIL single_fclk: got %b want 11100", cap_fclk); end
    if (cap_fs !== 5'b10000) begin errors++; $display("FAIL single_frame_start: got %b want 10000", cap_fs); end
    if (cap_sync !== 5'b00000) begin errors++; $display("FAIL single_sync_out: got %b want 00000", cap_sync); end
  endtask

  task automatic test_back_to_back();
    int   k;
    logic rdy;
    logic exp_bit;
    int   slot_err;
    int   rdy_err;
    do_reset();
    k             = 0;
    slot_err      = 0;
    rdy_err       = 0;
    bus.din       = {4{10'h3FF}};
    bus.din_valid = 1'b1;
    tick();
    k       = 1;
    bus.din = {4{10'h000}};
    checks++;
    if (bus.din_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_slot0: got %b want 0", bus.din_ready); end
    for (int j = 1; j <= 30; j++) begin
      rdy = bus.din_ready;
      tick();
      if (rdy) begin
        k++;
        bus.din = (k % 2 == 0) ? {4{10'h3FF}} : {4{10'h000}};
      end
      exp_bit = ((j / 5) % 2 == 1);
      if (bus.dout !== {8{exp_bit}}) slot_err++;
      if (bus.din_ready !== (j % 5 == 4)) rdy_err++;
    end
    bus.din_valid = 1'b0;
    checks += 3;
    if (slot_err != 0) begin errors++; $display("FAIL b2b_lanes: got %0d bad slots want 0", slot_err); end
    if (rdy_err != 0) begin errors++; $display("FAIL b2b_din_ready: got %0d bad cycles want 0", rdy_err); end
    if (bus.underflow_cnt !== 16'h0000) begin errors++; $display("FAIL b2b_underflow: got %h want 0000", bus.underflow_cnt); end
  endtask

  task automatic test_underflow();
    do_reset();
    bus.din       = {4{10'h3FF}};
    bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
    repeat (5) tick();
    checks++;
    if (bus.dout !== 8'hFF) begin errors++; $display("FAIL uf_data_frame: got %h want ff", bus.dout); end
    repeat (5) tick();
    checks += 2;
    if (bus.dout !== 8'h00) begin errors++; $display("FAIL uf_idle_frame: got %h want 00", bus.dout); end
    if (bus.underflow_cnt !== 16'd1) begin errors++; $display("FAIL uf_count1: got %0d want 1", bus.underflow_cnt); end
    repeat (10) tick();
    checks++;
    if (bus.underflow_cnt !== 16'd3) begin errors++; $display("FAIL uf_count3: got %0d want 3", bus.underflow_cnt); end
    force dut.r_underflow_cnt = 16'hFFFF;
    #1;
    release dut.r_underflow_cnt;
    repeat (5) tick();
    checks++;
    if (bus.underflow_cnt !== 16'hFFFF) begin errors++; $display("FAIL uf_saturate: got %h want ffff", bus.underflow_cnt); end
  endtask

  task automatic test_sync_mid_frame();
    int so_cnt;
    int fs_cnt;
    do_reset();
    bus.din       = {4{10'h2A5}};
    bus.din_valid = 1'b1;
    tick();
    bus.din = {4{10'h1C3}};
    repeat (5) tick();
    bus.din_valid = 1'b0;
    repeat (2) tick();
    bus.sync = 1'b1;
    tick();
    checks += 2;
    if (bus.sync_out !== 1'b1) begin errors++; $display("FAIL sync_out_pulse: got %b want 1", bus.sync_out); end
    if (bus.fclk_out !== 1'b1) begin errors++; $display("FAIL sync_fclk: got %b want 1", bus.fclk_out); end
    capture();
    // 1C3 -> hi 01110 lo 00011
    checks += 3;
    if ({cap_hi[2], cap_lo[2]} !== 10'h1C3) begin errors++; $display("FAIL sync_word: got %h want 1c3", {cap_hi[2], cap_lo[2]}); end
    if (cap_fs !== 5'b10000) begin errors++; $display("FAIL sync_frame_start: got %b want 10000", cap_fs); end
    if (cap_sync !== 5'b10000) begin errors++; $display("FAIL sync_marker: got %b want 10000", cap_sync); end
    so_cnt = 0;
    fs_cnt = 0;
    for (int j = 0; j < 20; j++) begin
      tick();
      if (bus.sync_out === 1'b1) so_cnt++;
      if (bus.frame_start === 1'b1) fs_cnt++;
    end
    bus.sync = 1'b0;
    checks += 2;
    if (so_cnt != 0) begin errors++; $display("FAIL sync_held_level: got %0d pulses want 0", so_cnt); end
    if (fs_cnt != 4) begin errors++; $display("FAIL sync_held_frames: got %0d want 4", fs_cnt); end
  endtask

  task automatic test_sync_on_boundary();
    do_reset();
    bus.din       = {4{10'h2A5}};
    bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
    repeat (4) tick();
    checks++;
    if (bus.din_ready !== 1'b1) begin errors++; $display("FAIL bnd_ready: got %b want 1", bus.din_ready); end
    bus.sync      = 1'b1;
    bus.din       = {4{10'h0F0}};
    bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
    capture();
    checks += 3;
    if ({cap_hi[1], cap_lo[1]} !== 10'h2A5) begin errors++; $display("FAIL bnd_word_a: got %h want 2a5", {cap_hi[1], cap_lo[1]}); end
    if (cap_fs !== 5'b10000) begin errors++; $display("FAIL bnd_single_load: got %b want 10000", cap_fs); end
    if (cap_sync !== 5'b10000) begin errors++; $display("FAIL bnd_sync_out: got %b want 10000", cap_sync); end
    tick();
    capture();
    // 0F0 -> hi 00111 lo 10000
    checks += 3;
    if ({cap_hi[3], cap_lo[3]} !== 10'h0F0) begin errors++; $display("FAIL bnd_word_c: got %h want 0f0", {cap_hi[3], cap_lo[3]}); end
    if (cap_sync !== 5'b00000) begin errors++; $display("FAIL bnd_no_second_sync: got %b want 00000", cap_sync); end
    if (bus.underflow_cnt !== 16'd0) begin errors++; $display("FAIL bnd_underflow: got %0d want 0", bus.underflow_cnt); end
    bus.sync = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.din       = {4{10'h3FF}};
    bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
    repeat (10) tick();
    bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
    repeat (7) tick();
    checks += 2;
    if (bus.dout !== 8'hFF) begin errors++; $display("FAIL ar_pre_dout: got %h want ff", bus.dout); end
    if (bus.underflow_cnt !== 16'd1) begin errors++; $display("FAIL ar_pre_underflow: got %0d want 1", bus.underflow_cnt); end
    rst = 1'b1;
    #1;
    checks += 4;
    if (bus.dout !== 8'h00) begin errors++; $display("FAIL ar_dout: got %h want 00", bus.dout); end
    if (bus.frame_start !== 1'b0) begin errors++; $display("FAIL ar_frame_start: got %b want 0", bus.frame_start); end
    if (bus.underflow_cnt !== 16'd0) begin errors++; $display("FAIL ar_underflow: got %0d want 0", bus.underflow_cnt); end
    if (bus.din_ready !== 1'b1) begin errors++; $display("FAIL ar_din_ready: got %b want 1", bus.din_ready); end
    #1;
    rst = 1'b0;
    tick();
    checks += 2;
    if (bus.frame_start !== 1'b1) begin errors++; $display("FAIL ar_first_load: got %b want 1", bus.frame_start); end
    if (bus.dout !== 8'h00) begin errors++; $display("FAIL ar_idle_frame: got %h want 00", bus.dout); end
    repeat (10) tick();
    checks++;
    if (bus.underflow_cnt !== 16'd0) begin errors++; $display("FAIL ar_unprimed: got %0d want 0", bus.underflow_cnt); end
  endtask

`ifdef ADS5296_TX_RAMP_EN
  task automatic test_ramp();
    test_mode = 1'b1;
    do_reset();
    bus.din       = {4{10'h3FF}};
    bus.din_valid = 1'b1;
    tick();
    checks++;
    if (bus.din_ready !== 1'b0) begin errors++; $display("FAIL ramp_ready: got %b want 0", bus.din_ready); end
    for (int f = 1; f <= 3; f++) begin
      capture();
      checks++;
      if ({cap_hi[1], cap_lo[1]} !== 10'(f)) begin
        errors++; $display("FAIL ramp_ch1_frame%0d: got %0d want %0d", f, {cap_hi[1], cap_lo[1]}, f);
      end
      tick();
    end
    bus.din_valid = 1'b0;
    test_mode     = 1'b0;
    checks++;
    if (bus.underflow_cnt !== 16'd0) begin errors++; $display("FAIL ramp_underflow: got %0d want 0", bus.underflow_cnt); end
  endtask
`endif

  initial begin
    rst           = 1'b1;
    bus.sync      = 1'b0;
    bus.din_valid = 1'b0;
    bus.din       = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_underflow();
    test_sync_mid_frame();
    test_sync_on_boundary();
    test_async_reset();
`ifdef ADS5296_TX_RAMP_EN
    test_ramp();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
